// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and the pixel/DAC side.
interface vga_timing_gen_if #(
    parameter int X_WIDTH = 11,
    parameter int Y_WIDTH = 10
);
    logic               enable;
    logic               blank_n;
    logic               sync_n;
    logic               h_sync;
    logic               v_sync;
    logic [X_WIDTH-1:0] next_x;
    logic [Y_WIDTH-1:0] next_y;
    logic               next_valid;
    logic               line_start;
    logic               frame_start;

    modport master (
        input  enable,
        output blank_n, sync_n, h_sync, v_sync,
        output next_x, next_y, next_valid, line_start, frame_start
    );

    modport slave (
        output enable,
        input  blank_n, sync_n, h_sync, v_sync,
        input  next_x, next_y, next_valid, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-clock divider,
// registered sync/blank outputs and one-pixel lookahead coordinates.
module vga_timing_gen #(
    parameter int H_DISPLAY     = 800,
    parameter int H_FRONT_PORCH = 56,
    parameter int H_SYNC_PULSE  = 120,
    parameter int H_BACK_PORCH  = 64,
    parameter int V_DISPLAY     = 600,
    parameter int V_FRONT_PORCH = 37,
    parameter int V_SYNC_PULSE  = 6,
    parameter int V_BACK_PORCH  = 23,
    parameter bit H_SYNC_POL    = 1'b0,
    parameter bit V_SYNC_POL    = 1'b0,
    parameter int PIX_DIV       = 1,
    parameter int X_WIDTH       = 11,
    parameter int Y_WIDTH       = 10
) (
    input logic              clk,
    input logic              rst,
    vga_timing_gen_if.master vif
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [X_WIDTH-1:0] H_LAST = X_WIDTH'(H_TOTAL - 1);
    localparam logic [X_WIDTH-1:0] H_VIS  = X_WIDTH'(H_DISPLAY);
    localparam logic [X_WIDTH-1:0] H_SS   = X_WIDTH'(H_DISPLAY + H_FRONT_PORCH);
    localparam logic [X_WIDTH-1:0] H_SE   = X_WIDTH'(H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [Y_WIDTH-1:0] V_LAST = Y_WIDTH'(V_TOTAL - 1);
    localparam logic [Y_WIDTH-1:0] V_VIS  = Y_WIDTH'(V_DISPLAY);
    localparam logic [Y_WIDTH-1:0] V_SS   = Y_WIDTH'(V_DISPLAY + V_FRONT_PORCH);
    localparam logic [Y_WIDTH-1:0] V_SE   = Y_WIDTH'(V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(PIX_DIV - 1);
    // Reset position is (0,0), so the lookahead starts at (1,0).
    localparam bit RST_NV = (H_DISPLAY > 1);

    logic [DIV_W-1:0]   div_count;
    logic [X_WIDTH-1:0] h_count, h1, h2;
    logic [Y_WIDTH-1:0] v_count, v1, v2;
    logic               tick, vis1, vis2, hs_act, vs_act;

    assign tick = vif.enable && (div_count == DIV_LAST);

    // Position one tick ahead (h1,v1) and two ticks ahead (h2,v2); outputs are
    // loaded from the first, the lookahead from the second.
    always_comb begin
        h1 = h_count + 1'b1;
        v1 = v_count;
        if (h_count == H_LAST) begin
            h1 = '0;
            if (v_count == V_LAST) v1 = '0;
            else                   v1 = v_count + 1'b1;
        end
        h2 = h1 + 1'b1;
        v2 = v1;
        if (h1 == H_LAST) begin
            h2 = '0;
            if (v1 == V_LAST) v2 = '0;
            else              v2 = v1 + 1'b1;
        end
        vis1   = (h1 < H_VIS) && (v1 < V_VIS);
        vis2   = (h2 < H_VIS) && (v2 < V_VIS);
        hs_act = (h1 >= H_SS) && (h1 < H_SE);
        vs_act = (v1 >= V_SS) && (v1 < V_SE);
    end

    // Pixel-clock divider; frozen while disabled so a stalled pixel resumes mid-count.
    always_ff @(posedge clk) begin
        if (rst)              div_count <= '0;
        else if (vif.enable)  div_count <= tick ? '0 : div_count + 1'b1;
    end

    // Raster counters and registered outputs, all updated together on a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_count         <= '0;
            v_count         <= '0;
            vif.blank_n     <= 1'b1;
            vif.h_sync      <= ~H_SYNC_POL;
            vif.v_sync      <= ~V_SYNC_POL;
            vif.sync_n      <= 1'b1;
            vif.next_x      <= RST_NV ? X_WIDTH'(1) : '0;
            vif.next_y      <= '0;
            vif.next_valid  <= RST_NV;
            vif.line_start  <= 1'b0;
            vif.frame_start <= 1'b0;
        end else begin
            // Strobes are single-cycle: only a tick onto column 0 raises them.
            vif.line_start  <= tick && (h1 == '0);
            vif.frame_start <= tick && (h1 == '0) && (v1 == '0);
            if (tick) begin
                h_count        <= h1;
                v_count        <= v1;
                vif.blank_n    <= vis1;
                vif.h_sync     <= hs_act ? H_SYNC_POL : ~H_SYNC_POL;
                vif.v_sync     <= vs_act ? V_SYNC_POL : ~V_SYNC_POL;
                vif.sync_n     <= ~(hs_act || vs_act);
                vif.next_valid <= vis2;
                vif.next_x     <= vis2 ? h2 : '0;
                vif.next_y     <= vis2 ? v2 : '0;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x600 timing over two lines, a small raster for
// full-frame, polarity and mid-frame reset checks, and PIX_DIV=3 with enable gaps.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.X_WIDTH(11), .Y_WIDTH(10)) d_if ();
    vga_timing_gen_if #(.X_WIDTH(4),  .Y_WIDTH(3))  s0_if ();
    vga_timing_gen_if #(.X_WIDTH(4),  .Y_WIDTH(3))  s1_if ();
    vga_timing_gen_if #(.X_WIDTH(4),  .Y_WIDTH(3))  s3_if ();

    vga_timing_gen u_d (.clk(clk), .rst(rst), .vif(d_if.master));

    // Small raster: H 8/2/3/2 (total 15, sync 10..12), V 4/1/2/1 (total 8, sync 5..6)
    vga_timing_gen #(.H_DISPLAY(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(2),
                     .V_DISPLAY(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
                     .X_WIDTH(4), .Y_WIDTH(3))
        u_s0 (.clk(clk), .rst(rst), .vif(s0_if.master));
    vga_timing_gen #(.H_DISPLAY(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(2),
                     .V_DISPLAY(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
                     .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .X_WIDTH(4), .Y_WIDTH(3))
        u_s1 (.clk(clk), .rst(rst), .vif(s1_if.master));
    vga_timing_gen #(.H_DISPLAY(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(2),
                     .V_DISPLAY(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
                     .PIX_DIV(3), .X_WIDTH(4), .Y_WIDTH(3))
        u_s3 (.clk(clk), .rst(rst), .vif(s3_if.master));

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_s0_reset();
        chk("s0_rst_blank",  int'(s0_if.blank_n), 1);
        chk("s0_rst_hsync",  int'(s0_if.h_sync), 1);
        chk("s0_rst_vsync",  int'(s0_if.v_sync), 1);
        chk("s0_rst_sync_n", int'(s0_if.sync_n), 1);
        chk("s0_rst_next_x", int'(s0_if.next_x), 1);
        chk("s0_rst_next_y", int'(s0_if.next_y), 0);
        chk("s0_rst_nvalid", int'(s0_if.next_valid), 1);
        chk("s0_rst_lstart", int'(s0_if.line_start), 0);
        chk("s0_rst_fstart", int'(s0_if.frame_start), 0);
    endtask

    // Expected small-raster outputs k enabled cycles after reset (PIX_DIV=1).
    task automatic chk_small(input int k);
        int p, l, np, nl;
        bit ha, va, nv;
        p  = k % 15;
        l  = (k / 15) % 8;
        ha = (p >= 10) && (p < 13);
        va = (l >= 5) && (l < 7);
        np = (p + 1) % 15;
        nl = (p == 14) ? (l + 1) % 8 : l;
        nv = (np < 8) && (nl < 4);
        chk("s0_blank",  int'(s0_if.blank_n), int'((p < 8) && (l < 4)));
        chk("s0_hsync",  int'(s0_if.h_sync), int'(!ha));
        chk("s0_vsync",  int'(s0_if.v_sync), int'(!va));
        chk("s0_sync_n", int'(s0_if.sync_n), int'(!(ha || va)));
        chk("s1_hsync",  int'(s1_if.h_sync), int'(ha));
        chk("s1_vsync",  int'(s1_if.v_sync), int'(va));
        chk("s1_sync_n", int'(s1_if.sync_n), int'(!(ha || va)));
        chk("s0_lstart", int'(s0_if.line_start), int'(p == 0));
        chk("s0_fstart", int'(s0_if.frame_start), int'(p == 0 && l == 0));
        chk("s0_nvalid", int'(s0_if.next_valid), int'(nv));
        chk("s0_next_x", int'(s0_if.next_x), nv ? np : 0);
        chk("s0_next_y", int'(s0_if.next_y), nv ? nl : 0);
    endtask

    initial begin
        int hs_low, ls_cnt, fs_cnt, fs_first;
        d_if.enable  = 1'b1;
        s0_if.enable = 1'b1;
        s1_if.enable = 1'b1;
        s3_if.enable = 1'b0;

        // Reset state
        step(2);
        chk("d_rst_blank",  int'(d_if.blank_n), 1);
        chk("d_rst_hsync",  int'(d_if.h_sync), 1);
        chk("d_rst_vsync",  int'(d_if.v_sync), 1);
        chk("d_rst_sync_n", int'(d_if.sync_n), 1);
        chk("d_rst_next_x", int'(d_if.next_x), 1);
        chk("d_rst_next_y", int'(d_if.next_y), 0);
        chk("d_rst_nvalid", int'(d_if.next_valid), 1);
        chk("d_rst_lstart", int'(d_if.line_start), 0);
        chk("d_rst_fstart", int'(d_if.frame_start), 0);
        chk("s1_rst_hsync", int'(s1_if.h_sync), 0);
        chk("s1_rst_vsync", int'(s1_if.v_sync), 0);
        chk("s1_rst_sync_n", int'(s1_if.sync_n), 1);
        rst = 1'b0;

        // Default timing, two lines plus a few pixels
        hs_low = 0;
        ls_cnt = 0;
        for (int k = 1; k <= 2085; k++) begin
            int p, l, np, nl;
            bit ha, nv;
            step(1);
            p  = k % 1040;
            l  = k / 1040;
            ha = (p >= 856) && (p < 976);
            np = (p + 1) % 1040;
            nl = (p == 1039) ? l + 1 : l;
            nv = (np < 800) && (nl < 600);
            chk("d_blank",  int'(d_if.blank_n), int'((p < 800) && (l < 600)));
            chk("d_hsync",  int'(d_if.h_sync), int'(!ha));
            chk("d_vsync",  int'(d_if.v_sync), 1);
            chk("d_sync_n", int'(d_if.sync_n), int'(!ha));
            chk("d_lstart", int'(d_if.line_start), int'(p == 0));
            chk("d_fstart", int'(d_if.frame_start), 0);
            chk("d_nvalid", int'(d_if.next_valid), int'(nv));
            chk("d_next_x", int'(d_if.next_x), nv ? np : 0);
            chk("d_next_y", int'(d_if.next_y), nv ? nl : 0);
            if (k <= 1040 && d_if.h_sync == 1'b0) hs_low++;
            if (d_if.line_start) ls_cnt++;
            if (k == 1) begin
                chk("d_tick1_next_x", int'(d_if.next_x), 2);
                chk("d_tick1_blank",  int'(d_if.blank_n), 1);
            end
            if (k == 799) begin
                chk("d_h799_nvalid", int'(d_if.next_valid), 0);
                chk("d_h799_next_x", int'(d_if.next_x), 0);
            end
            if (k == 1039) begin
                chk("d_h1039_next_x", int'(d_if.next_x), 0);
                chk("d_h1039_next_y", int'(d_if.next_y), 1);
                chk("d_h1039_nvalid", int'(d_if.next_valid), 1);
            end
        end
        chk("d_hsync_low_cnt", hs_low, 120);
        chk("d_lstart_cnt", ls_cnt, 2);

        // Small raster: two full frames, both polarities
        rst = 1'b1;
        step(1);
        chk_s0_reset();
        chk("s1_rst2_hsync", int'(s1_if.h_sync), 0);
        rst = 1'b0;
        fs_cnt   = 0;
        fs_first = -1;
        for (int k = 1; k <= 241; k++) begin
            step(1);
            chk_small(k);
            if (s0_if.frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = k;
            end
            if (k == 119) begin
                chk("s0_last_nvalid", int'(s0_if.next_valid), 1);
                chk("s0_last_next_x", int'(s0_if.next_x), 0);
                chk("s0_last_next_y", int'(s0_if.next_y), 0);
            end
        end
        chk("s0_fstart_cnt", fs_cnt, 2);
        chk("s0_fstart_first", fs_first, 120);
        // s3 has been disabled throughout: still in reset state
        chk("s3_hold_next_x", int'(s3_if.next_x), 1);
        chk("s3_hold_blank",  int'(s3_if.blank_n), 1);
        chk("s3_hold_lstart", int'(s3_if.line_start), 0);

        // Mid-frame reset at (6,3), then the same timing again from zero
        step(50);
        chk("s0_pre_rst_next_x", int'(s0_if.next_x), 7);
        rst = 1'b1;
        step(1);
        chk_s0_reset();
        rst = 1'b0;
        for (int k = 1; k <= 125; k++) begin
            step(1);
            chk_small(k);
        end

        // PIX_DIV=3 with enable pattern 1,1,0,0,1
        s3_if.enable = 1'b1;
        step(1);
        chk("s3_e1_next_x", int'(s3_if.next_x), 1);
        step(1);
        chk("s3_e2_next_x", int'(s3_if.next_x), 1);
        s3_if.enable = 1'b0;
        step(1);
        chk("s3_d1_next_x", int'(s3_if.next_x), 1);
        step(1);
        chk("s3_d2_next_x", int'(s3_if.next_x), 1);
        chk("s3_d2_lstart", int'(s3_if.line_start), 0);
        s3_if.enable = 1'b1;
        step(1);
        chk("s3_e3_next_x", int'(s3_if.next_x), 2);
        chk("s3_e3_blank",  int'(s3_if.blank_n), 1);
        chk("s3_e3_lstart", int'(s3_if.line_start), 0);
        step(41);
        chk("s3_h14_lstart", int'(s3_if.line_start), 0);
        chk("s3_h14_next_x", int'(s3_if.next_x), 0);
        chk("s3_h14_next_y", int'(s3_if.next_y), 1);
        chk("s3_h14_nvalid", int'(s3_if.next_valid), 1);
        step(1);
        chk("s3_wrap_lstart", int'(s3_if.line_start), 1);
        chk("s3_wrap_fstart", int'(s3_if.frame_start), 0);
        chk("s3_wrap_next_x", int'(s3_if.next_x), 1);
        chk("s3_wrap_next_y", int'(s3_if.next_y), 1);
        s3_if.enable = 1'b0;
        step(1);
        chk("s3_off_lstart", int'(s3_if.line_start), 0);
        chk("s3_off_next_x", int'(s3_if.next_x), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
